// File: rtl/int_halt_ctrl.sv
// Interrupt/halt sequencer: latches int_req edges, drains the pipeline, then pulses sf1 and vectors the PC.
// Latency: int_req sampled high -> DRAIN 2 cycles later -> sf1 after DRAIN_CYCLES more (+2 with INT_SYNC_EN).
// Backpressure: none; HLT parks the core in HALT until an interrupt or rst. Option macro: INT_SYNC_EN.
module int_halt_ctrl #(
    parameter logic [7:0] VEC_ADDR     = 8'h01,
    parameter int         DRAIN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic       hlt_en,
    input  logic       rti_wb,
    output logic       sf1,
    output logic       freeze_fetch,
    output logic       pc_sel_vec,
    output logic [7:0] vec_addr,
    output logic       int_active,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAVE,
        ST_VECTOR,
        ST_ISR,
        ST_HALT
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       int_in;
    logic       int_prev;
    logic       rise_q;
    logic       int_pending;
    logic       enter_save;

`ifdef INT_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer for an int_req coming from another clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= int_req;
            sync2 <= sync1;
        end
    end

    assign int_in = sync2;
`else
    assign int_in = int_req;
`endif

    assign vec_addr = VEC_ADDR;

    // Rising-edge detector; the detected edge is registered so a held level yields one request.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_prev <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            int_prev <= int_in;
            rise_q   <= int_in & ~int_prev;
        end
    end

    assign enter_save = (next_state == ST_SAVE) && (state != ST_SAVE);

    // Pending request flag: a new edge wins over the clear caused by entering SAVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_pending <= 1'b0;
        end else if (rise_q) begin
            int_pending <= 1'b1;
        end else if (enter_save) begin
            int_pending <= 1'b0;
        end
    end

    // State and drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; HLT beats a pending interrupt, RTI only matters inside the ISR.
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            ST_IDLE: begin
                if (hlt_en) begin
                    next_state = ST_HALT;
                end else if (int_pending) begin
                    next_state = ST_DRAIN;
                    cnt_nxt    = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                if (hlt_en) begin
                    next_state = ST_HALT;
                end else if (cnt == 4'd0) begin
                    next_state = ST_SAVE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_SAVE:   next_state = ST_VECTOR;
            ST_VECTOR: next_state = ST_ISR;
            ST_ISR: begin
                if (rti_wb) begin
                    next_state = ST_IDLE;
                end
            end
            ST_HALT: begin
                // Pipeline is already empty in HALT, so skip the drain.
                if (int_pending) begin
                    next_state = ST_SAVE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Moore outputs registered from the next state so they change with the state flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sf1          <= 1'b0;
            freeze_fetch <= 1'b0;
            pc_sel_vec   <= 1'b0;
            int_active   <= 1'b0;
            halted       <= 1'b0;
        end else begin
            sf1          <= (next_state == ST_SAVE);
            freeze_fetch <= (next_state == ST_DRAIN) || (next_state == ST_SAVE) ||
                            (next_state == ST_VECTOR) || (next_state == ST_HALT);
            pc_sel_vec   <= (next_state == ST_VECTOR);
            int_active   <= (next_state == ST_SAVE) || (next_state == ST_VECTOR) ||
                            (next_state == ST_ISR);
            halted       <= (next_state == ST_HALT);
        end
    end

endmodule
